// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: glyph table, blank pattern, FSM states and decode result type for the seven-segment scan decoder
package seg7_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLING, HOLD} state_t;
  typedef struct packed {
    logic [3:0] nibble;
    logic blank;
    logic err;
  } dec_t;
  localparam logic [6:0] BLANK_PATTERN = 7'h7F;
  // Active-low {a,b,c,d,e,f,g}; entry k is the glyph for hex digit k
  localparam logic [6:0] GLYPHS [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  localparam logic [6:0] NINE_WITH_D = 7'h04;
  localparam logic [6:0] SEVEN_WITH_F = 7'h0D;
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: maps an active-low segment pattern to a hex nibble with blank/error flags
module seg7_glyph_decode
  import seg7_scan_pkg::*;
(
  input  logic [6:0] seg,
  output dec_t       res
);
  always_comb begin
    res = '{nibble: 4'h0, blank: seg == BLANK_PATTERN, err: seg != BLANK_PATTERN};
    for (int k = 0; k < 16; k++)
      if (seg == GLYPHS[k]) res = '{nibble: 4'(k), blank: 1'b0, err: 1'b0};
    if (seg == NINE_WITH_D) res = '{nibble: 4'h9, blank: 1'b0, err: 1'b0};
    if (seg == SEVEN_WITH_F) res = '{nibble: 4'h7, blank: 1'b0, err: 1'b0};
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: passive monitor that rebuilds 8-digit frames from a multiplexed seven-segment scan
// Define SEG7_SCAN_DP_CAPTURE_EN to capture decimal points into dp_out.
module seg7_scan_decoder
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   E,
  input  logic [6:0]              CA2G,
  input  logic                    dp,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    frame_valid,
  output logic                    anode_err,
  output logic                    stale
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [NUM_DIGITS-1:0] e_q, e_prev, sel, seen, cap_bit, sh_blank, sh_err, sh_blank_nx, sh_err_nx;
  logic [4*NUM_DIGITS-1:0] sh_val, sh_val_nx;
  logic [6:0] seg_q;
  logic [CW-1:0] cnt, cnt_nx, run;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic none, one, multi, changed, cap, commit;
  state_t state, state_nx;
  dec_t dec;
  seg7_glyph_decode u_dec (.seg(seg_q), .res(dec));
  assign sel = ~e_q;
  assign none = sel == '0;
  assign one = !none && ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign multi = !none && !one;
  assign changed = e_q != e_prev;
  assign run = (state == SETTLING && !changed) ? cnt + CW'(1) : CW'(1);
  assign commit = &seen;
  assign tcnt_nx = commit ? '0 : (tcnt == TW'(TIMEOUT) ? tcnt : tcnt + TW'(1));
  // A held digit in HOLD is ignored until the anodes move, so each dwell captures once
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    cap = 1'b0;
    if (state != HOLD || changed) begin
      cnt_nx = run;
      cap = one && run >= CW'(SETTLE);
      state_nx = !one ? IDLE : cap ? HOLD : SETTLING;
    end
  end
  always_comb begin
    cap_bit = cap ? sel : '0;
    sh_blank_nx = (sh_blank & ~cap_bit) | (cap_bit & {NUM_DIGITS{dec.blank}});
    sh_err_nx = (sh_err & ~cap_bit) | (cap_bit & {NUM_DIGITS{dec.err}});
    sh_val_nx = sh_val;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cap_bit[i]) sh_val_nx[4*i+:4] = dec.nibble;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '1;
      e_prev <= '1;
      seg_q <= BLANK_PATTERN;
      state <= IDLE;
      cnt <= '0;
      seen <= '0;
      sh_val <= '0;
      sh_blank <= '0;
      sh_err <= '0;
      tcnt <= '0;
      value <= '0;
      blank_mask <= '0;
      err_mask <= '0;
      frame_valid <= 1'b0;
      anode_err <= 1'b0;
      stale <= 1'b0;
    end else begin
      e_q <= E;
      e_prev <= e_q;
      seg_q <= CA2G;
      state <= state_nx;
      cnt <= cnt_nx;
      anode_err <= multi && changed;
      frame_valid <= commit;
      sh_val <= sh_val_nx;
      sh_blank <= sh_blank_nx;
      sh_err <= sh_err_nx;
      seen <= commit ? '0 : seen | cap_bit;
      tcnt <= tcnt_nx;
      stale <= tcnt_nx == TW'(TIMEOUT);
      if (commit) begin
        value <= sh_val_nx;
        blank_mask <= sh_blank_nx;
        err_mask <= sh_err_nx;
      end
    end
  end
`ifdef SEG7_SCAN_DP_CAPTURE_EN
  logic dp_q;
  logic [NUM_DIGITS-1:0] sh_dp, sh_dp_nx;
  assign sh_dp_nx = (sh_dp & ~cap_bit) | (cap_bit & {NUM_DIGITS{~dp_q}});
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_q <= 1'b1;
      sh_dp <= '0;
      dp_out <= '0;
    end else begin
      dp_q <= dp;
      sh_dp <= sh_dp_nx;
      if (commit) dp_out <= sh_dp_nx;
    end
  end
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign dp_out = '0;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scans with hand-computed frames for seg7_scan_decoder
module tb_seg7_scan_decoder;
  logic clk = 1'b0, reset = 1'b1, dp = 1'b1;
  logic [7:0] E = '1;
  logic [6:0] CA2G = 7'h7F;
  logic [31:0] value;
  logic [7:0] blank_mask, err_mask, dp_out;
  logic frame_valid, anode_err, stale;
  int compared = 0, mismatched = 0, fv_cnt = 0, ae_cnt = 0;
  localparam logic [6:0] GL [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  always #5 clk = ~clk;
  seg7_scan_decoder #(.NUM_DIGITS(8), .SETTLE(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .E(E), .CA2G(CA2G), .dp(dp), .value(value),
    .blank_mask(blank_mask), .err_mask(err_mask), .dp_out(dp_out),
    .frame_valid(frame_valid), .anode_err(anode_err), .stale(stale)
  );
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (anode_err) ae_cnt++;
  end
  function automatic logic [55:0] hex_glyphs(input logic [31:0] h);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i+:7] = GL[h[4*i+:4]];
    return r;
  endfunction
  task automatic show(input int idx, input logic [6:0] g, input logic dp_lit, input int hold);
    E = ~(8'b1 << idx);
    CA2G = g;
    dp = ~dp_lit;
    repeat (hold) @(negedge clk);
  endtask
  task automatic idle(input int n);
    E = '1;
    CA2G = 7'h7F;
    dp = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [55:0] g, input logic [7:0] dp_lit, input int short_idx);
    for (int i = 0; i < 8; i++) show(i, g[7*i+:7], dp_lit[i], i == short_idx ? 3 : 10);
    idle(4);
  endtask
  task automatic do_reset();
    idle(1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    compared += 6;
    if (value !== 32'h0) begin mismatched++; $display("FAIL reset_value: got %h want 0", value); end
    if (blank_mask !== 8'h0) begin mismatched++; $display("FAIL reset_blank: got %h want 0", blank_mask); end
    if (err_mask !== 8'h0) begin mismatched++; $display("FAIL reset_err: got %h want 0", err_mask); end
    if (dp_out !== 8'h0) begin mismatched++; $display("FAIL reset_dp: got %h want 0", dp_out); end
    if ({frame_valid, anode_err} !== 2'b00) begin mismatched++; $display("FAIL reset_pulses: got %b want 00", {frame_valid, anode_err}); end
    if (stale !== 1'b0) begin mismatched++; $display("FAIL reset_stale: got %b want 0", stale); end
  endtask
  task automatic test_basic_scan();
    int f0 = fv_cnt;
    scan(hex_glyphs(32'h87654321), 8'h00, -1);
    compared += 4;
    if (fv_cnt - f0 !== 1) begin mismatched++; $display("FAIL basic_frames: got %0d want 1", fv_cnt - f0); end
    if (value !== 32'h87654321) begin mismatched++; $display("FAIL basic_value: got %h want 87654321", value); end
    if (blank_mask !== 8'h00) begin mismatched++; $display("FAIL basic_blank: got %h want 00", blank_mask); end
    if (err_mask !== 8'h00) begin mismatched++; $display("FAIL basic_err: got %h want 00", err_mask); end
  endtask
  task automatic test_back_to_back();
    int f0 = fv_cnt;
    for (int i = 0; i < 8; i++) show(i, GL[4'(8 - i)], 1'b0, 10);
    for (int i = 0; i < 8; i++) show(i, GL[4'(i + 1)], 1'b0, 10);
    idle(4);
    compared += 2;
    if (fv_cnt - f0 !== 2) begin mismatched++; $display("FAIL b2b_frames: got %0d want 2", fv_cnt - f0); end
    if (value !== 32'h87654321) begin mismatched++; $display("FAIL b2b_value: got %h want 87654321", value); end
  endtask
  task automatic test_short_dwell();
    int f0 = fv_cnt;
    scan(hex_glyphs(32'h87654321), 8'h00, 3);
    compared += 1;
    if (fv_cnt - f0 !== 0) begin mismatched++; $display("FAIL short_no_frame: got %0d want 0", fv_cnt - f0); end
    show(3, GL[12], 1'b0, 5);
    idle(4);
    compared += 2;
    if (fv_cnt - f0 !== 1) begin mismatched++; $display("FAIL short_late_frame: got %0d want 1", fv_cnt - f0); end
    if (value !== 32'h8765C321) begin mismatched++; $display("FAIL short_value: got %h want 8765c321", value); end
  endtask
  task automatic test_anode_err();
    int f0 = fv_cnt, a0 = ae_cnt;
    E = 8'hFC;
    CA2G = GL[5];
    repeat (5) @(negedge clk);
    idle(4);
    compared += 2;
    if (ae_cnt - a0 !== 1) begin mismatched++; $display("FAIL multi_pulses: got %0d want 1", ae_cnt - a0); end
    if (fv_cnt - f0 !== 0) begin mismatched++; $display("FAIL multi_frames: got %0d want 0", fv_cnt - f0); end
    scan(hex_glyphs(32'h13572468), 8'h00, -1);
    compared += 2;
    if (fv_cnt - f0 !== 1) begin mismatched++; $display("FAIL multi_recover_frames: got %0d want 1", fv_cnt - f0); end
    if (value !== 32'h13572468) begin mismatched++; $display("FAIL multi_recover_value: got %h want 13572468", value); end
  endtask
  task automatic test_blank_err();
    logic [55:0] g = hex_glyphs(32'h76543210);
    g[35+:7] = 7'h7F;
    g[14+:7] = 7'h00;
    scan(g, 8'h00, -1);
    compared += 3;
    if (value !== 32'h76043810) begin mismatched++; $display("FAIL blank_value: got %h want 76043810", value); end
    if (blank_mask !== 8'h20) begin mismatched++; $display("FAIL blank_mask: got %h want 20", blank_mask); end
    if (err_mask !== 8'h00) begin mismatched++; $display("FAIL blank_err: got %h want 00", err_mask); end
    g[14+:7] = 7'h3E;
    scan(g, 8'h00, -1);
    compared += 3;
    if (value !== 32'h76043010) begin mismatched++; $display("FAIL err_value: got %h want 76043010", value); end
    if (blank_mask !== 8'h20) begin mismatched++; $display("FAIL err_blank: got %h want 20", blank_mask); end
    if (err_mask !== 8'h04) begin mismatched++; $display("FAIL err_mask: got %h want 04", err_mask); end
  endtask
  task automatic test_alt_glyphs();
    logic [55:0] g = hex_glyphs(32'hFEDCBA98);
    g[0+:7] = 7'h04;
    g[7+:7] = 7'h0D;
    scan(g, 8'h00, -1);
    compared += 2;
    if (value !== 32'hFEDCBA79) begin mismatched++; $display("FAIL alt_value: got %h want fedcba79", value); end
    if (err_mask !== 8'h00) begin mismatched++; $display("FAIL alt_err: got %h want 00", err_mask); end
  endtask
  task automatic test_reset_mid();
    int f0 = fv_cnt;
    for (int i = 0; i < 5; i++) show(i, GL[4'(15 - i)], 1'b0, 10);
    do_reset();
    compared += 2;
    if (fv_cnt - f0 !== 0) begin mismatched++; $display("FAIL midreset_frames: got %0d want 0", fv_cnt - f0); end
    if (value !== 32'h0) begin mismatched++; $display("FAIL midreset_cleared: got %h want 0", value); end
    for (int i = 0; i < 3; i++) show(5 + i, GL[4'(10 - i)], 1'b0, 10);
    idle(4);
    compared += 1;
    if (fv_cnt - f0 !== 0) begin mismatched++; $display("FAIL midreset_partial: got %0d want 0", fv_cnt - f0); end
    scan(hex_glyphs(32'h89ABCDEF), 8'h00, -1);
    compared += 2;
    if (fv_cnt - f0 !== 1) begin mismatched++; $display("FAIL midreset_post_frames: got %0d want 1", fv_cnt - f0); end
    if (value !== 32'h89ABCDEF) begin mismatched++; $display("FAIL midreset_value: got %h want 89abcdef", value); end
  endtask
  task automatic test_stale();
    int f0;
    do_reset();
    repeat (990) @(negedge clk);
    compared += 1;
    if (stale !== 1'b0) begin mismatched++; $display("FAIL stale_early: got %b want 0", stale); end
    repeat (20) @(negedge clk);
    compared += 1;
    if (stale !== 1'b1) begin mismatched++; $display("FAIL stale_set: got %b want 1", stale); end
    f0 = fv_cnt;
    scan(hex_glyphs(32'h24681357), 8'h00, -1);
    compared += 3;
    if (fv_cnt - f0 !== 1) begin mismatched++; $display("FAIL stale_frames: got %0d want 1", fv_cnt - f0); end
    if (stale !== 1'b0) begin mismatched++; $display("FAIL stale_cleared: got %b want 0", stale); end
    if (value !== 32'h24681357) begin mismatched++; $display("FAIL stale_value: got %h want 24681357", value); end
  endtask
  task automatic test_dp();
    logic [7:0] exp_dp;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
    exp_dp = 8'h81;
`else
    exp_dp = 8'h00;
`endif
    scan(hex_glyphs(32'h11223344), 8'h81, -1);
    compared += 2;
    if (dp_out !== exp_dp) begin mismatched++; $display("FAIL dp_out: got %h want %h", dp_out, exp_dp); end
    if (value !== 32'h11223344) begin mismatched++; $display("FAIL dp_value: got %h want 11223344", value); end
  endtask
  initial begin
    test_reset();
    test_basic_scan();
    test_back_to_back();
    test_short_dwell();
    test_anode_err();
    test_blank_err();
    test_alt_glyphs();
    test_reset_mid();
    test_stale();
    test_dp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
